pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised program-counter generator for the IF stage; successor to the fixed 32-bit PC register.
//  Issues fetch addresses to instruction memory over a valid/ready handshake and advances by STEP.
//  Also supports pipeline stall, branch/jump redirect, exception redirect and misaligned-target detection.
//  Sits between the control unit (stall, redirects) and instruction ROM; pc/ce feed IF/ID.
// PARAMETERS
//  ADDR_W     32            width of pc and all target addresses
//  STEP       4             byte increment per sequential fetch (power of two, >=1)
//  RESET_VEC  32'h0000_0000 first fetch address after reset (truncated to ADDR_W)
//  EXC_VEC    32'h0000_0020 exception handler address (truncated to ADDR_W)
// PORTS
//  clk          in   1       single clock; all logic on posedge
//  rst          in   1       synchronous reset, active-high
//  stall        in   1       hold pc; no advance (redirects still win)
//  br_valid     in   1       branch/jump taken this cycle
//  br_target    in   ADDR_W  branch/jump destination
//  exc_valid    in   1       exception taken this cycle; redirect to EXC_VEC
//  req_ready    in   1       instruction memory accepts current pc
//  pc           out  ADDR_W  current fetch address
//  ce           out  1       chip enable / request valid to instruction memory
//  redirected   out  1       1-cycle pulse: pc was loaded from a redirect
//  misalign     out  1       1-cycle pulse: br_target had nonzero bits below log2(STEP)
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=BOOT, pc=RESET_VEC, ce=0, redirected=0, misalign=0.
//  States: BOOT -> RUN. BOOT lasts exactly one cycle after rst deasserts (ce stays 0),
//   then RUN with ce=1 and pc=RESET_VEC; first fetch is RESET_VEC, never RESET_VEC+STEP.
//  Redirects in BOOT are ignored. rst in any state returns to BOOT on the next edge.
//  In RUN, next-pc priority per edge (highest first):
//   1 exc_valid            -> pc=EXC_VEC, redirected=1
//   2 br_valid             -> pc={br_target[ADDR_W-1:log2 STEP],0s}, redirected=1, misalign=|low bits
//   3 stall                -> pc held
//   4 ce & req_ready       -> pc=pc+STEP, modulo 2^ADDR_W (wraps all-ones region to 0, no flag)
//   5 otherwise            -> pc held (request outstanding; pc/ce stable until accepted)
//  Redirect abandons any outstanding unaccepted request; memory must not rely on it.
//  Redirect and req_ready same cycle: redirect wins; accepted word is discarded downstream.
//  redirected/misalign are registered, high exactly the cycle the new pc is presented.
//  ce=1 throughout RUN, including during stall (stall only freezes pc).
//  Latency: redirect inputs at edge N -> new pc visible after edge N, i.e. 1 cycle.
//  No combinational path from any input to any output.
// TESTING
//  rst 3 cycles then release, req_ready=1 -> ce=0 one cycle, then pc=0,4,8,C with ce=1.
//  req_ready=0 two cycles at pc=8 -> pc holds 8, ce=1; ready=1 -> pc=C next cycle.
//  stall=1 two cycles at pc=10 -> pc=10 held; br_valid with target 40 during stall -> pc=40, redirected=1.
//  exc_valid and br_valid same cycle, target 100 -> pc=EXC_VEC(20), redirected=1, misalign=0.
//  br_target=0x47 -> pc=44, misalign=1 for one cycle; next accepted fetch pc=48.
//  ADDR_W=8, pc=FC, ready=1 -> pc=00 (wrap); rst asserted mid-stall -> pc=RESET_VEC, ce=0.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: IF-stage program-counter generator.
// Issues fetch addresses to instruction memory and advances by STEP on acceptance.
// Handles pipeline stall, branch/jump redirect and exception redirect.
// Flags branch targets that are not STEP-aligned.
//
// Handshake: ce is the request valid and pc is the request payload.
// A request is accepted on a posedge where ce=1 and req_ready=1.
// While a request is outstanding (ce=1, req_ready=0), pc and ce hold stable.
// The one exception is a redirect: it replaces pc, and the outstanding request is abandoned.
// All outputs come from registers, so there is no combinational path from any input.
module pc_gen #(
  parameter int          ADDR_W    = 32,
  parameter int          STEP      = 4,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_0020
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              exc_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              redirected,
  output logic              misalign
);

  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(EXC_VEC);
  localparam logic [ADDR_W-1:0] STEP_INC = ADDR_W'(STEP);
  // Bits below log2(STEP). This mask is empty when STEP=1, which avoids a zero-width slice.
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(STEP - 1);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Named state register, kept visible for hierarchical checkers.
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              redirected_q, redirected_d;
  logic              misalign_q, misalign_d;

  // Register update with synchronous reset back to BOOT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      redirected_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redirected_q <= redirected_d;
      misalign_q   <= misalign_d;
    end
  end

  // Next state and next pc, in priority order: exception, branch, stall, accept, hold.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redirected_d = 1'b0;
    misalign_d   = 1'b0;
    unique case (state_q)
      BOOT: begin
        // One idle cycle with ce low. Redirects are ignored here.
        // The first fetch is RESET_PC, not RESET_PC+STEP.
        state_d = RUN;
        pc_d    = RESET_PC;
      end
      RUN: begin
        if (exc_valid) begin
          pc_d         = EXC_PC;
          redirected_d = 1'b1;
        end else if (br_valid) begin
          pc_d         = br_target & ~LOW_MASK;
          redirected_d = 1'b1;
          misalign_d   = |(br_target & LOW_MASK);
        end else if (stall) begin
          pc_d = pc_q;
        end else if (req_ready) begin
          // ce is always 1 in RUN, so acceptance only needs req_ready.
          // The addition wraps modulo 2^ADDR_W.
          pc_d = pc_q + STEP_INC;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        state_d = BOOT;
        pc_d    = RESET_PC;
      end
    endcase
  end

  assign pc         = pc_q;
  assign ce         = (state_q == RUN);
  assign redirected = redirected_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen.
// Main instance: 32-bit address. Second instance: 8-bit address, for the wrap case.
module tb_pc_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        rst, stall, br_valid, exc_valid, req_ready;
  logic [31:0] br_target;
  logic [31:0] pc;
  logic        ce, redirected, misalign;

  // 8-bit instance signals
  logic        rst8, stall8, br_valid8, exc_valid8, req_ready8;
  logic [7:0]  br_target8;
  logic [7:0]  pc8;
  logic        ce8, redirected8, misalign8;

  pc_gen #(
    .ADDR_W(32), .STEP(4), .RESET_VEC(32'h0000_0000), .EXC_VEC(32'h0000_0020)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_target(br_target),
    .exc_valid(exc_valid), .req_ready(req_ready), .pc(pc), .ce(ce),
    .redirected(redirected), .misalign(misalign)
  );

  pc_gen #(
    .ADDR_W(8), .STEP(4), .RESET_VEC(32'h0000_0000), .EXC_VEC(32'h0000_0020)
  ) dut8 (
    .clk(clk), .rst(rst8), .stall(stall8), .br_valid(br_valid8), .br_target(br_target8),
    .exc_valid(exc_valid8), .req_ready(req_ready8), .pc(pc8), .ce(ce8),
    .redirected(redirected8), .misalign(misalign8)
  );

  // ---------------- scoreboard ----------------
  // Expected word layout: {misalign, redirected, ce, pc}.
  logic [34:0] exp_q[$];
  logic [10:0] exp8_q[$];
  int checks = 0;
  int errors = 0;

  // Monitor: the DUT presents a new output every cycle after an edge.
  // Pop and compare on the opposite edge.
  always @(negedge clk) begin
    logic [34:0] e;
    logic [10:0] e8;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({misalign, redirected, ce, pc} !== e) begin
        errors++;
        $display("FAIL dut32 got pc=%h ce=%b red=%b mis=%b exp pc=%h ce=%b red=%b mis=%b",
                 pc, ce, redirected, misalign, e[31:0], e[32], e[33], e[34]);
      end
    end
    if (exp8_q.size() > 0) begin
      e8 = exp8_q.pop_front();
      checks++;
      if ({misalign8, redirected8, ce8, pc8} !== e8) begin
        errors++;
        $display("FAIL dut8 got pc=%h ce=%b red=%b mis=%b exp pc=%h ce=%b red=%b mis=%b",
                 pc8, ce8, redirected8, misalign8, e8[7:0], e8[8], e8[9], e8[10]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Apply inputs for one edge, then queue the outputs expected right after that edge.
  task automatic step(input logic r, input logic st, input logic bv, input logic [31:0] bt,
                      input logic ev, input logic rr,
                      input logic [31:0] e_pc, input logic e_ce, input logic e_red,
                      input logic e_mis);
    rst = r; stall = st; br_valid = bv; br_target = bt; exc_valid = ev; req_ready = rr;
    @(posedge clk);
    exp_q.push_back({e_mis, e_red, e_ce, e_pc});
    #1;
  endtask

  task automatic step8(input logic r, input logic bv, input logic [7:0] bt, input logic rr,
                       input logic [7:0] e_pc, input logic e_ce, input logic e_red,
                       input logic e_mis);
    rst8 = r; stall8 = 1'b0; br_valid8 = bv; br_target8 = bt; exc_valid8 = 1'b0;
    req_ready8 = rr;
    @(posedge clk);
    exp8_q.push_back({e_mis, e_red, e_ce, e_pc});
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; stall = 1'b0; br_valid = 1'b0; br_target = '0; exc_valid = 1'b0;
    req_ready = 1'b1;
    rst8 = 1'b1; stall8 = 1'b0; br_valid8 = 1'b0; br_target8 = '0; exc_valid8 = 1'b0;
    req_ready8 = 1'b1;

    //   rst st bv target        ev rr   exp_pc        ce red mis
    // Reset held for 3 cycles.
    step(1, 0, 0, 32'h0,         0, 1,   32'h0000_0000, 0, 0, 0);
    step(1, 0, 0, 32'h0,         0, 1,   32'h0000_0000, 0, 0, 0);
    step(1, 0, 0, 32'h0,         0, 1,   32'h0000_0000, 0, 0, 0);
    // BOOT -> RUN: the first fetch is RESET_VEC, then 4, 8.
    step(0, 0, 0, 32'h0,         0, 1,   32'h0000_0000, 1, 0, 0);
    step(0, 0, 0, 32'h0,         0, 1,   32'h0000_0004, 1, 0, 0);
    step(0, 0, 0, 32'h0,         0, 1,   32'h0000_0008, 1, 0, 0);
    // Memory not ready: pc holds at 8 with ce=1.
    step(0, 0, 0, 32'h0,         0, 0,   32'h0000_0008, 1, 0, 0);
    step(0, 0, 0, 32'h0,         0, 0,   32'h0000_0008, 1, 0, 0);
    step(0, 0, 0, 32'h0,         0, 1,   32'h0000_000C, 1, 0, 0);
    step(0, 0, 0, 32'h0,         0, 1,   32'h0000_0010, 1, 0, 0);
    // Stall holds 10 even with ready=1; a branch during stall still redirects.
    step(0, 1, 0, 32'h0,         0, 1,   32'h0000_0010, 1, 0, 0);
    step(0, 1, 0, 32'h0,         0, 1,   32'h0000_0010, 1, 0, 0);
    step(0, 1, 1, 32'h0000_0040, 0, 1,   32'h0000_0040, 1, 1, 0);
    step(0, 0, 0, 32'h0,         0, 1,   32'h0000_0044, 1, 0, 0);
    // Exception beats branch.
    step(0, 0, 1, 32'h0000_0100, 1, 1,   32'h0000_0020, 1, 1, 0);
    // Misaligned branch target: low bits are cleared and flagged; the next fetch is 48.
    step(0, 0, 1, 32'h0000_0047, 0, 1,   32'h0000_0044, 1, 1, 1);
    step(0, 0, 0, 32'h0,         0, 1,   32'h0000_0048, 1, 0, 0);
    // A branch with no acceptance abandons the outstanding request.
    step(0, 0, 1, 32'h0000_0200, 0, 0,   32'h0000_0200, 1, 1, 0);
    step(0, 0, 0, 32'h0,         0, 0,   32'h0000_0200, 1, 0, 0);
    // Reset asserted mid-stall.
    step(0, 1, 0, 32'h0,         0, 1,   32'h0000_0200, 1, 0, 0);
    step(1, 1, 0, 32'h0,         0, 1,   32'h0000_0000, 0, 0, 0);
    // Redirects during BOOT are ignored.
    step(0, 0, 1, 32'h0000_0080, 1, 1,   32'h0000_0000, 1, 0, 0);
    step(0, 0, 0, 32'h0,         0, 1,   32'h0000_0004, 1, 0, 0);
    // Exception while stalled.
    step(0, 1, 0, 32'h0,         1, 0,   32'h0000_0020, 1, 1, 0);

    // 8-bit instance: wrap from FC to 00, plus a misaligned target.
    //    rst bv tgt    rr  exp  ce red mis
    step8(1, 0, 8'h00, 1,  8'h00, 0, 0, 0);
    step8(0, 0, 8'h00, 1,  8'h00, 1, 0, 0);
    step8(0, 1, 8'hFC, 1,  8'hFC, 1, 1, 0);
    step8(0, 0, 8'h00, 1,  8'h00, 1, 0, 0);
    step8(0, 0, 8'h00, 1,  8'h04, 1, 0, 0);
    step8(0, 1, 8'hFF, 0,  8'hFC, 1, 1, 1);
    step8(0, 0, 8'h00, 1,  8'h00, 1, 0, 0);

    // Drain: the monitor must have consumed every expectation within a bounded time.
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || exp8_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending exp 0/0", exp_q.size(), exp8_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
